// File: rtl/sram_ctr_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the SRAM controller slice.
package sram_ctr_ahb_pkg;
  localparam int ADDR_W_DEF = 12;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BST_SINGLE = 3'b000;
  localparam logic [2:0] BST_INCR   = 3'b001;
  localparam logic [2:0] BST_WRAP4  = 3'b010;
  localparam logic [2:0] BST_INCR4  = 3'b011;
  localparam logic [2:0] BST_WRAP8  = 3'b100;
  localparam logic [2:0] BST_INCR8  = 3'b101;
  localparam logic [2:0] BST_WRAP16 = 3'b110;
  localparam logic [2:0] BST_INCR16 = 3'b111;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RDWAIT, S_RDDONE, S_ERR1, S_ERR2
  } state_t;
endpackage

// File: rtl/sram_ctr_ahb_decode.sv
// Combinational address-phase decode: accept, illegal and active-low byte lanes.
module sram_ctr_ahb_decode
  import sram_ctr_ahb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hready_in,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  output logic        accept,
  output logic        illegal,
  output logic [3:0]  lanes
);
  logic bad_size, misalign, out_rng;
  logic unused_addr;

  assign unused_addr = ^haddr[ADDR_W+1:2];

  assign accept   = hsel & hready_in & htrans[1];
  assign bad_size = hsize > SZ_WORD;
  assign misalign = ((hsize == SZ_HALF) && haddr[0]) ||
                    ((hsize == SZ_WORD) && (haddr[1:0] != 2'b00));
  assign out_rng  = |haddr[31:ADDR_W+2];
  assign illegal  = bad_size | misalign | out_rng;

  always_comb begin
    lanes = 4'hF;
    case (hsize)
      SZ_WORD: lanes = 4'b0000;
      SZ_HALF: lanes = haddr[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: lanes = ~(4'b0001 << haddr[1:0]);
      default: lanes = 4'hF;
    endcase
  end
endmodule

// File: rtl/sram_ctr_ahb_fsm.sv
// Transfer sequencer for the AHB-Lite SRAM slave: SRAM strobes, wait states,
// two-cycle ERROR response and the address-register hold (error_check).
module sram_ctr_ahb_fsm
  import sram_ctr_ahb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_WAIT = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hready_in,
  output logic        hreadyout,
  output logic        hresp,
  output logic        error_check,
  output logic        sram_cen,
  output logic [3:0]  sram_wen,
  output logic        sram_oen
);
  localparam logic [1:0] WAIT_INIT = 2'(RD_WAIT - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       accept, illegal, decode_ok;
  logic [3:0] lanes;

  sram_ctr_ahb_decode #(.ADDR_W(ADDR_W)) u_decode (
    .hsel      (hsel),
    .htrans    (htrans),
    .hready_in (hready_in),
    .hsize     (hsize),
    .haddr     (haddr),
    .accept    (accept),
    .illegal   (illegal),
    .lanes     (lanes)
  );

  // States in which the slave is ready and the pipelined phase is decoded;
  // RDDONE belongs here so back-to-back reads advance the address register.
  assign decode_ok   = (state == S_IDLE) || (state == S_WRITE) || (state == S_RDDONE);
  assign error_check = ~accept | illegal | ~decode_ok;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_WRITE, S_RDDONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (illegal)     state_nxt = S_ERR1;
          else if (hwrite) state_nxt = S_WRITE;
          else begin
            state_nxt = S_RDWAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_RDWAIT: begin
        if (cnt == 2'd0) state_nxt = S_RDDONE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      S_ERR2:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free
  // and line up with the data phase they belong to.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      sram_cen  <= 1'b1;
      sram_wen  <= 4'hF;
      sram_oen  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hreadyout <= !((state_nxt == S_RDWAIT) || (state_nxt == S_ERR1));
      hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      sram_cen  <= !((state_nxt == S_WRITE) || (state_nxt == S_RDWAIT));
      sram_wen  <= (state_nxt == S_WRITE) ? lanes : 4'hF;
      sram_oen  <= !((state_nxt == S_RDWAIT) || (state_nxt == S_RDDONE));
    end
  end
endmodule
